// File: rtl/vm2_vic.sv
// vm2_vic -- vectored interrupt controller for the 1801VM2 processor module.
//
// It collects NREQ level-sensitive peripheral requests and arbitrates them by
// fixed priority, with index 0 the highest. It raises the CPU's vectored
// request line, then answers the CPU's vector-fetch strobe with the winning
// vector and a one-cycle acknowledge pulse to that source.
//
// Ports:
//   clk_p      system clock, rising edge
//   rst_n      asynchronous active-low reset
//   init_i     synchronous bus init; same effect as reset
//   irq_i      level request per source (bit i = source i)
//   mask_i     per-source enable (1 = enabled)
//   vec_i      16-bit vector per source, source i at [16i+15:16i]
//   virq_o     vectored interrupt request to the CPU
//   istb_i     vector-fetch strobe from the CPU
//   ivec_o     vector presented to the CPU
//   iack_o     vector valid / acknowledge to the CPU
//   src_ack_o  one-cycle acknowledge pulse to the winning source
//   busy_o     high while in ACK or DONE
module vm2_vic #(
  parameter int          NREQ     = 8,
  parameter logic [15:0] SPUR_VEC = 16'o000000
) (
  input  logic              clk_p,
  input  logic              rst_n,
  input  logic              init_i,
  input  logic [NREQ-1:0]   irq_i,
  input  logic [NREQ-1:0]   mask_i,
  input  logic [NREQ*16-1:0] vec_i,
  output logic              virq_o,
  input  logic              istb_i,
  output logic [15:0]       ivec_o,
  output logic              iack_o,
  output logic [NREQ-1:0]   src_ack_o,
  output logic              busy_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, REQ, ACK, DONE} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   winner, winner_n;
  logic            virq_n, iack_n, busy_n;
  logic [15:0]     ivec_n;
  logic [NREQ-1:0] src_ack_n;

  logic [NREQ-1:0] pend;
  logic            has_pend;
  logic [IW-1:0]   low;
  logic [15:0]     grant_vec;
  logic [NREQ-1:0] grant_ack;

  assign pend     = irq_i & mask_i;
  assign has_pend = |pend;

  // Scanning from the top down lets the lowest set index overwrite the
  // others, so the result is the highest-priority pending source.
  always_comb begin : lowest_enc
    low = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pend[i]) low = IW'(i);
    end
  end

  // The grant is taken from pend as it stands at the strobe edge. A strobe
  // with nothing pending gets the spurious vector and no source pulse.
  assign grant_vec = has_pend ? vec_i[16*int'(low) +: 16] : SPUR_VEC;
  assign grant_ack = has_pend ? (NREQ'(1) << low) : '0;

  always_comb begin : next_state
    // NOTE: every output of this block gets a default before the case
    // statement, so no path leaves a value unassigned and no latch is inferred.
    state_n   = state;
    winner_n  = winner;
    virq_n    = 1'b0;
    ivec_n    = ivec_o;
    iack_n    = iack_o;
    src_ack_n = '0;

    unique case (state)
      IDLE, REQ: begin
        if (istb_i) begin
          // A strobe in IDLE covers a CPU fetch that arrives without virq.
          state_n   = ACK;
          winner_n  = low;
          ivec_n    = grant_vec;
          iack_n    = 1'b1;
          src_ack_n = grant_ack;
        end else if (has_pend) begin
          // Re-evaluated every cycle in REQ, so a higher-priority arrival
          // preempts before the strobe.
          state_n  = REQ;
          winner_n = low;
          virq_n   = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      ACK: begin
        // ivec_o and iack_o hold by default, so a vec_i change is not seen.
        if (!istb_i) begin
          state_n = DONE;
          iack_n  = 1'b0;
          ivec_n  = '0;
        end
      end
      DONE: begin
        // One holdoff cycle so the acknowledged source can drop irq_i.
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (init_i) begin
      state_n   = IDLE;
      winner_n  = '0;
      virq_n    = 1'b0;
      ivec_n    = '0;
      iack_n    = 1'b0;
      src_ack_n = '0;
    end

    busy_n = (state_n == ACK) || (state_n == DONE);
  end

  // NOTE: this design has no memories. Every state bit is a plain flop and is
  // cleared by the asynchronous reset.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      winner    <= '0;
      virq_o    <= 1'b0;
      ivec_o    <= '0;
      iack_o    <= 1'b0;
      src_ack_o <= '0;
      busy_o    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so all flops
      // update together from values computed before the edge.
      state     <= state_n;
      winner    <= winner_n;
      virq_o    <= virq_n;
      ivec_o    <= ivec_n;
      iack_o    <= iack_n;
      src_ack_o <= src_ack_n;
      busy_o    <= busy_n;
    end
  end

endmodule

// File: tb/tb_vm2_vic.sv
// tb_vm2_vic -- self-checking bench for vm2_vic.
//
// A transaction-level reference model tracks each grant, the holdoff after
// it, and the request line. It is checked against the DUT every cycle. The
// directed steps additionally check the constant values the protocol
// requires.
module tb_vm2_vic;

  localparam int          NREQ     = 8;
  localparam logic [15:0] SPUR_VEC = 16'o000000;

  logic               clk_p = 1'b0;
  logic               rst_n;
  logic               init_i;
  logic [NREQ-1:0]    irq_i;
  logic [NREQ-1:0]    mask_i;
  logic [NREQ*16-1:0] vec_i;
  logic               istb_i;
  logic               virq_o;
  logic [15:0]        ivec_o;
  logic               iack_o;
  logic [NREQ-1:0]    src_ack_o;
  logic               busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  vm2_vic #(.NREQ(NREQ), .SPUR_VEC(SPUR_VEC)) dut (
    .clk_p     (clk_p),
    .rst_n     (rst_n),
    .init_i    (init_i),
    .irq_i     (irq_i),
    .mask_i    (mask_i),
    .vec_i     (vec_i),
    .virq_o    (virq_o),
    .istb_i    (istb_i),
    .ivec_o    (ivec_o),
    .iack_o    (iack_o),
    .src_ack_o (src_ack_o),
    .busy_o    (busy_o)
  );

  always #5 clk_p = ~clk_p;

  // Reference model. It tracks whether a vector is being served, how many
  // holdoff cycles remain, and the expected value of each output.
  bit              m_granted = 1'b0;
  int              m_holdoff = 0;
  logic            m_virq    = 1'b0;
  logic            m_iack    = 1'b0;
  logic [15:0]     m_ivec    = '0;
  logic [NREQ-1:0] m_src_ack = '0;

  always @(posedge clk_p or negedge rst_n) begin
    logic [NREQ-1:0] p;
    int first;
    if (!rst_n) begin
      m_granted = 1'b0; m_holdoff = 0; m_virq = 1'b0;
      m_iack = 1'b0; m_ivec = '0; m_src_ack = '0;
    end else begin
      p = irq_i & mask_i;
      first = -1;
      for (int i = 0; i < NREQ; i++) if (p[i] && first < 0) first = i;
      m_src_ack = '0;
      if (init_i) begin
        m_granted = 1'b0; m_holdoff = 0; m_virq = 1'b0;
        m_iack = 1'b0; m_ivec = '0;
      end else if (m_granted) begin
        if (!istb_i) begin
          m_granted = 1'b0; m_iack = 1'b0; m_ivec = '0; m_holdoff = 1;
        end
      end else if (m_holdoff > 0) begin
        m_holdoff--;
        m_virq = 1'b0;
      end else if (istb_i) begin
        m_granted = 1'b1; m_iack = 1'b1; m_virq = 1'b0;
        m_ivec = (first >= 0) ? vec_i[first*16 +: 16] : SPUR_VEC;
        if (first >= 0) m_src_ack[first] = 1'b1;
      end else begin
        m_virq = (p != '0);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge, and compare
  // against the model.
  task automatic cycle();
    @(posedge clk_p);
    #1;
    check("m_virq",    32'(virq_o),    32'(m_virq));
    check("m_iack",    32'(iack_o),    32'(m_iack));
    check("m_ivec",    32'(ivec_o),    32'(m_ivec));
    check("m_src_ack", 32'(src_ack_o), 32'(m_src_ack));
    check("m_busy",    32'(busy_o),    32'(m_granted || (m_holdoff > 0)));
  endtask

  initial begin
    rst_n = 1'b0; init_i = 1'b0; irq_i = '0; mask_i = '1; vec_i = '0; istb_i = 1'b0;
    @(posedge clk_p); @(posedge clk_p); #1;
    check("rst_virq", 32'(virq_o), 0);
    check("rst_iack", 32'(iack_o), 0);
    check("rst_ivec", 32'(ivec_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    rst_n = 1'b1;

    // Single source.
    vec_i[3*16 +: 16] = 16'o000100;
    irq_i = 8'h08;
    cycle(); check("t1_virq", 32'(virq_o), 1);
    istb_i = 1'b1;
    cycle();
    check("t1_iack", 32'(iack_o), 1);
    check("t1_ivec", 32'(ivec_o), 32'(16'o000100));
    check("t1_sack", 32'(src_ack_o), 32'h08);
    check("t1_virq0", 32'(virq_o), 0);
    irq_i = '0;
    cycle(); check("t1_sack0", 32'(src_ack_o), 0);
    check("t1_iack_hold", 32'(iack_o), 1);
    istb_i = 1'b0;
    cycle(); check("t1_iack0", 32'(iack_o), 0); check("t1_done_busy", 32'(busy_o), 1);
    cycle(); check("t1_idle_busy", 32'(busy_o), 0);

    // Priority and preemption, then holdoff gap.
    vec_i[1*16 +: 16] = 16'o000060;
    vec_i[5*16 +: 16] = 16'o000064;
    irq_i = 8'h20;
    cycle(); check("t2_virq", 32'(virq_o), 1);
    irq_i = 8'h22;
    cycle();
    istb_i = 1'b1;
    cycle();
    check("t2_ivec", 32'(ivec_o), 32'(16'o000060));
    check("t2_sack", 32'(src_ack_o), 32'h02);
    irq_i = 8'h20; istb_i = 1'b0;
    cycle(); check("t2_gap1", 32'(virq_o), 0);
    cycle(); check("t2_gap2", 32'(virq_o), 0);
    cycle(); check("t2_gap3", 32'(virq_o), 1);
    istb_i = 1'b1;
    cycle(); check("t2_ivec5", 32'(ivec_o), 32'(16'o000064)); check("t2_sack5", 32'(src_ack_o), 32'h20);
    irq_i = '0; istb_i = 1'b0;
    cycle(); cycle();

    // Withdrawal, then spurious strobe.
    irq_i = 8'h04;
    cycle(); check("t3_virq1", 32'(virq_o), 1);
    cycle();
    irq_i = '0;
    cycle(); check("t3_virq0", 32'(virq_o), 0); check("t3_nosack", 32'(src_ack_o), 0);
    istb_i = 1'b1;
    cycle();
    check("t3_iack", 32'(iack_o), 1);
    check("t3_spur", 32'(ivec_o), 32'(SPUR_VEC));
    check("t3_sack", 32'(src_ack_o), 0);
    istb_i = 1'b0;
    cycle(); cycle();

    // Masking.
    irq_i = 8'h01; mask_i = 8'h00;
    cycle(); cycle(); check("t4_masked", 32'(virq_o), 0);
    mask_i = 8'h01;
    cycle(); check("t4_unmask", 32'(virq_o), 1);
    mask_i = 8'h00;
    cycle(); check("t4_remask", 32'(virq_o), 0);
    mask_i = '1; irq_i = '0;
    cycle();

    // Asynchronous reset in ACK, then init in ACK.
    vec_i[0 +: 16] = 16'o000200;
    irq_i = 8'h01;
    cycle();
    istb_i = 1'b1;
    cycle(); check("t5_ack", 32'(iack_o), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_iack", 32'(iack_o), 0);
    check("t5_async_virq", 32'(virq_o), 0);
    check("t5_async_ivec", 32'(ivec_o), 0);
    cycle();
    rst_n = 1'b1;
    cycle(); check("t5_reack", 32'(iack_o), 1);
    init_i = 1'b1;
    cycle();
    check("t5_init_iack", 32'(iack_o), 0);
    check("t5_init_ivec", 32'(ivec_o), 0);
    check("t5_init_busy", 32'(busy_o), 0);
    init_i = 1'b0; istb_i = 1'b0; irq_i = '0;
    cycle();

    // Vector stability during ACK.
    vec_i[3*16 +: 16] = 16'o000100;
    irq_i = 8'h08;
    cycle();
    istb_i = 1'b1;
    cycle(); check("t6_ivec", 32'(ivec_o), 32'(16'o000100));
    vec_i[3*16 +: 16] = 16'o000777;
    cycle(); check("t6_stable1", 32'(ivec_o), 32'(16'o000100));
    cycle(); check("t6_stable2", 32'(ivec_o), 32'(16'o000100));
    istb_i = 1'b0; irq_i = '0;
    cycle(); check("t6_clear", 32'(ivec_o), 0);
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      irq_i  = NREQ'($urandom) & NREQ'($urandom);
      mask_i = NREQ'($urandom) | NREQ'($urandom);
      if ($urandom_range(0, 7) == 0)
        for (int k = 0; k < NREQ; k++) vec_i[k*16 +: 16] = 16'($urandom);
      istb_i = ($urandom_range(0, 9) < 3);
      init_i = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
